// File: rtl/bcd_conv_pkg.sv
// Shared types and helpers for the sequential BCD code converter.
//   mode_t    : conversion mode (BCD->Gray, Gray->BCD, BCD->Excess-3, passthrough)
//   state_t   : controller states
//   idx_width : width of a digit index for a given digit count (never below 1)
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        MODE_B2G  = 2'd0,
        MODE_G2B  = 2'd1,
        MODE_XS3  = 2'd2,
        MODE_PASS = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/bcd_code_converter_seq_if.sv
// Handshake and data bundle for bcd_code_converter_seq.
//   start, mode, data_in             : requester -> converter
//   busy, done, code_out, err,
//   err_digit                        : converter -> requester
// The converter uses the slave modport, the requester the master modport.
interface bcd_code_converter_seq_if #(
    parameter int DIGITS = 4
);
    import bcd_conv_pkg::*;

    localparam int IDXW = idx_width(DIGITS);

    logic                  start;
    logic [1:0]            mode;
    logic [4*DIGITS-1:0]   data_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   code_out;
    logic                  err;
    logic [IDXW-1:0]       err_digit;

    modport master (
        output start, mode, data_in,
        input  busy, done, code_out, err, err_digit
    );

    modport slave (
        input  start, mode, data_in,
        output busy, done, code_out, err, err_digit
    );

endinterface

// File: rtl/digit_code_conv.sv
// Single-digit combinational code converter.
//   digit   : 4-bit input digit
//   mode    : conversion mode
//   result  : converted digit, 4'hF when the digit is invalid
//   invalid : digit (or decoded digit for Gray->BCD) is not a BCD value
module digit_code_conv
    import bcd_conv_pkg::*;
(
    input  logic [3:0] digit,
    input  mode_t      mode,
    output logic [3:0] result,
    output logic       invalid
);

    logic [3:0] gray_dec;

    // Gray decode ripples from the MSB: each binary bit is the previous
    // binary bit xor the current Gray bit.
    always_comb begin
        gray_dec[3] = digit[3];
        gray_dec[2] = gray_dec[3] ^ digit[2];
        gray_dec[1] = gray_dec[2] ^ digit[1];
        gray_dec[0] = gray_dec[1] ^ digit[0];
    end

    always_comb begin
        result  = digit;
        invalid = 1'b0;
        case (mode)
            MODE_B2G: begin
                invalid = (digit > 4'd9);
                result  = {digit[3], digit[3] ^ digit[2],
                           digit[2] ^ digit[1], digit[1] ^ digit[0]};
            end
            MODE_G2B: begin
                invalid = (gray_dec > 4'd9);
                result  = gray_dec;
            end
            MODE_XS3: begin
                invalid = (digit > 4'd9);
                result  = digit + 4'd3;
            end
            MODE_PASS: begin
                invalid = 1'b0;
                result  = digit;
            end
            default: begin
                invalid = 1'b0;
                result  = digit;
            end
        endcase
        if (invalid) begin
            result = 4'hF;
        end
    end

endmodule

// File: rtl/bcd_code_converter_seq.sv
// Sequential multi-digit code converter: one digit per clock, LSD first,
// through a single shared digit_code_conv.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of bcd_code_converter_seq_if (start/mode/data_in in;
//         busy/done/code_out/err/err_digit out)
//
// state | meaning
// IDLE  | waiting for start
// CONV  | converting digit idx_q, one digit per cycle
// DONE  | one-cycle done pulse; outputs just updated; start re-arms
module bcd_code_converter_seq
    import bcd_conv_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    bcd_code_converter_seq_if.slave  bus
);

    localparam int IDXW = idx_width(DIGITS);
    localparam int W    = 4 * DIGITS;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    data_q;
    mode_t           mode_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    result_q;
    logic            err_acc_q;
    logic [IDXW-1:0] err_idx_q;

    logic [W-1:0]    code_q;
    logic            err_q;
    logic [IDXW-1:0] err_digit_q;

    logic [3:0]      dig_in;
    logic [3:0]      dig_out;
    logic            dig_bad;
    logic            last_digit;
    logic            accept;
    logic [W-1:0]    result_nxt;
    logic            err_nxt;
    logic [IDXW-1:0] err_idx_nxt;

    digit_code_conv u_digit_conv (
        .digit   (dig_in),
        .mode    (mode_q),
        .result  (dig_out),
        .invalid (dig_bad)
    );

    assign dig_in     = data_q[4*int'(idx_q) +: 4];
    assign last_digit = (idx_q == IDXW'(DIGITS - 1));
    assign accept     = bus.start && (state != CONV);

    // Accumulators including the digit being converted this cycle, so the
    // last digit lands in the outputs on the same edge that enters DONE.
    always_comb begin
        result_nxt                        = result_q;
        result_nxt[4*int'(idx_q) +: 4]    = dig_out;
        err_nxt                           = err_acc_q | dig_bad;
        err_idx_nxt                       = err_idx_q;
        if (dig_bad && !err_acc_q) begin
            err_idx_nxt = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (last_digit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = bus.start ? CONV : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            mode_q    <= MODE_B2G;
            idx_q     <= '0;
            result_q  <= '0;
            err_acc_q <= 1'b0;
            err_idx_q <= '0;
        end else if (accept) begin
            data_q    <= bus.data_in;
            mode_q    <= mode_t'(bus.mode);
            idx_q     <= '0;
            result_q  <= '0;
            err_acc_q <= 1'b0;
            err_idx_q <= '0;
        end else if (state == CONV) begin
            result_q  <= result_nxt;
            err_acc_q <= err_nxt;
            err_idx_q <= err_idx_nxt;
            if (!last_digit) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q      <= '0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else if (state == CONV && last_digit) begin
            code_q      <= result_nxt;
            err_q       <= err_nxt;
            err_digit_q <= err_nxt ? err_idx_nxt : '0;
        end
    end

    assign bus.busy      = (state == CONV);
    assign bus.done      = (state == DONE);
    assign bus.code_out  = code_q;
    assign bus.err       = err_q;
    assign bus.err_digit = err_digit_q;

endmodule

// File: tb/tb_bcd_code_converter_seq.sv
// Self-checking bench for bcd_code_converter_seq (DIGITS=4): directed
// vectors, randomized words against an arithmetic reference model,
// back-to-back starts, ignored starts while busy, and mid-conversion reset.
module tb_bcd_code_converter_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    bcd_code_converter_seq_if #(.DIGITS(DIGITS)) bus ();

    bcd_code_converter_seq #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: per-digit arithmetic on the mode rules.
    function automatic void model(input logic [W-1:0] d, input int m,
                                  output logic [W-1:0] c, output logic e, output int ed);
        c  = '0;
        e  = 1'b0;
        ed = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int x;
            int y;
            bit bad;
            x   = int'(d[4*i +: 4]);
            y   = x;
            bad = 1'b0;
            case (m)
                0: begin bad = (x > 9); y = x ^ (x >> 1); end
                1: begin y = x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3); bad = (y > 9); end
                2: begin bad = (x > 9); y = (x + 3) % 16; end
                default: begin bad = 1'b0; y = x; end
            endcase
            if (bad) begin
                y = 15;
                if (!e) ed = i;
                e = 1'b1;
            end
            c[4*i +: 4] = y[3:0];
        end
    endfunction

    // Called just after a negedge in IDLE or DONE. Returns at the negedge
    // where done is seen (or after the cycle budget runs out).
    task automatic do_word(input logic [W-1:0] d, input logic [1:0] m, input bit noise,
                           input string tag);
        logic [W-1:0] exp_c;
        logic         exp_e;
        int           exp_ed;
        int           lat;
        model(d, int'(m), exp_c, exp_e, exp_ed);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.mode    = m;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = W'($urandom);
        bus.mode    = 2'($urandom);
        chk({tag, "_busy_t1"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.done && lat < 20) begin
            bus.start = (noise && lat == 2);
            if (noise && lat == 2) begin
                bus.data_in = W'($urandom);
                bus.mode    = 2'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(DIGITS + 1));
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_code"}, 32'(bus.code_out), 32'(exp_c));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_e));
        chk({tag, "_err_digit"}, 32'(bus.err_digit), 32'(exp_ed));
    endtask

    task automatic to_idle(input string tag, input logic [W-1:0] held);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold"}, 32'(bus.code_out), 32'(held));
    endtask

    function automatic logic [W-1:0] rand_word(input int m);
        logic [W-1:0] w;
        bit           valid_only;
        w          = '0;
        valid_only = ($urandom_range(0, 1) == 0);
        for (int i = 0; i < DIGITS; i++) begin
            int x;
            x = valid_only ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
            if (m == 1 && valid_only) x = x ^ (x >> 1);
            w[4*i +: 4] = x[3:0];
        end
        return w;
    endfunction

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.mode    = 2'd0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_code", 32'(bus.code_out), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_digit", 32'(bus.err_digit), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_word(16'h1239, 2'd0, 1'b0, "b2g");
        chk("b2g_const", 32'(bus.code_out), 32'h132D);
        to_idle("b2g", 16'h132D);
        do_word(16'h132D, 2'd1, 1'b1, "g2b");
        chk("g2b_const", 32'(bus.code_out), 32'h1239);
        to_idle("g2b", 16'h1239);
        do_word(16'h0459, 2'd2, 1'b0, "xs3");
        chk("xs3_const", 32'(bus.code_out), 32'h378C);
        to_idle("xs3", 16'h378C);
        do_word(16'hB2A4, 2'd0, 1'b1, "bad");
        chk("bad_const", 32'(bus.code_out), 32'hF3F6);
        chk("bad_err_const", 32'(bus.err_digit), 32'd1);
        to_idle("bad", 16'hF3F6);

        // Back-to-back: second start issued in the DONE cycle of the first.
        do_word(16'h1239, 2'd0, 1'b0, "b2b1");
        do_word(16'h0000, 2'd3, 1'b0, "b2b2");
        chk("b2b2_const", 32'(bus.code_out), 32'h0000);
        to_idle("b2b2", 16'h0000);

        // Reset during conversion.
        do_word(16'h9876, 2'd2, 1'b0, "pre_rst");
        bus.start   = 1'b1;
        bus.data_in = 16'h1111;
        bus.mode    = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_code", 32'(bus.code_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (DIGITS + 2) begin
            @(negedge clk);
            chk("aborted_no_done", 32'(bus.done), 32'd0);
        end
        do_word(16'h0805, 2'd0, 1'b0, "post_rst");
        chk("post_rst_const", 32'(bus.code_out), 32'h0C07);
        to_idle("post_rst", 16'h0C07);

        for (int k = 0; k < 40; k++) begin
            int m;
            m = int'($urandom_range(0, 3));
            do_word(rand_word(m), 2'(m), ($urandom_range(0, 1) == 1), "rand");
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk("rand_idle_done", 32'(bus.done), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
